// File: rtl/hall_rotation_counter.sv
// ---------------------------------------------------------------------------
// hall_rotation_counter
//
// Counts Hall-sensor edges against a programmable target entirely in the
// system clock domain. The raw Hall line is synchronised, glitch-filtered and
// edge-detected, and the resulting one-clock qualified-edge pulses drive a
// small move FSM (IDLE / LOAD / COUNT / DONE, plus STALL when enabled). The
// FSM sits in front of the servo position controller: flag is high while a
// move is loading or in progress and drops on the clock the target is reached.
//
// Parameters
//   CNT_W        width of cin/count; target range 0..2^CNT_W-1
//   FILT_LEN     glitch-filter depth in clocks; 0 bypasses the filter
//   EDGE_MODE    0 = rising Hall edges qualify, 1 = rising and falling
//   STALL_CYCLES stall timeout in clocks (exists only with the macro below)
//
// Optional feature
//   ROT_STALL_TIMEOUT_EN  when defined, a timer runs while counting and is
//                         cleared by every qualified edge; if it reaches
//                         STALL_CYCLES the FSM parks in STALL (stall=1,
//                         flag stays 1, count frozen) until change=1 or
//                         RESET. When undefined, stall is tied to 0.
//
// Ports
//   CLK     in   1      system clock, all logic on its rising edge
//   RESET   in   1      synchronous active-high reset
//   hallIn  in   1      raw Hall sensor, asynchronous to CLK
//   change  in   1      level: 1 = hold/load a new target, 0 = run
//   cin     in   CNT_W  target edge count, sampled every clock change=1
//   flag    out  1      1 = busy (loading or counting), 0 = idle/done
//   count   out  CNT_W  qualified edges counted since the last load
//   done    out  1      one-clock pulse on the clock flag falls at target
//   stall   out  1      stall indicator (0 unless the macro is defined)
//
// Latency from a stable hallIn change to the count update is 3+FILT_LEN
// clocks: two synchroniser flops, FILT_LEN filter samples, one count update.
// ---------------------------------------------------------------------------
module hall_rotation_counter #(
    parameter int CNT_W     = 6,
    parameter int FILT_LEN  = 2,
    parameter int EDGE_MODE = 0
`ifdef ROT_STALL_TIMEOUT_EN
    ,
    parameter int STALL_CYCLES = 1000
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             hallIn,
    input  logic             change,
    input  logic [CNT_W-1:0] cin,
    output logic             flag,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             stall
);

`ifdef ROT_STALL_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COUNT = 3'd2,
        DONE  = 3'd3,
        STALL = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;
`endif

    // -----------------------------------------------------------------------
    // Stage p0/p1: two-flop synchroniser for the asynchronous Hall line
    // -----------------------------------------------------------------------
    logic hall_sync_p0;
    logic hall_sync_p1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hall_sync_p0 <= 1'b0;
            hall_sync_p1 <= 1'b0;
        end else begin
            hall_sync_p0 <= hallIn;
            hall_sync_p1 <= hall_sync_p0;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p2: glitch filter
    // -----------------------------------------------------------------------
    logic hall_filt_p2;

    generate
        if (FILT_LEN == 0) begin : g_no_filt
            assign hall_filt_p2 = hall_sync_p1;
        end else begin : g_filt
            // run counts consecutive samples that disagree with the held
            // level; the level only moves once FILT_LEN of them line up.
            localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

            logic [RUN_W-1:0] run;
            logic             level;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    run   <= '0;
                    level <= 1'b0;
                end else if (hall_sync_p1 == level) begin
                    run <= '0;
                end else if (run == RUN_W'(FILT_LEN - 1)) begin
                    level <= hall_sync_p1;
                    run   <= '0;
                end else begin
                    run <= run + 1'b1;
                end
            end

            assign hall_filt_p2 = level;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Stage p3: edge detect against the previous filtered level
    // -----------------------------------------------------------------------
    logic hall_prev_p3;
    logic hall_edge;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hall_prev_p3 <= 1'b0;
        end else begin
            hall_prev_p3 <= hall_filt_p2;
        end
    end

    // The pulse is combinational so the counter sees it on the very next
    // clock; it lasts exactly one clock because hall_prev_p3 catches up.
    generate
        if (EDGE_MODE == 0) begin : g_rise_only
            assign hall_edge = hall_filt_p2 & ~hall_prev_p3;
        end else begin : g_both_edges
            assign hall_edge = hall_filt_p2 ^ hall_prev_p3;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Move FSM: registered state and outputs, combinational next values
    // -----------------------------------------------------------------------
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] target_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] count_inc;
    logic             flag_n;
    logic             done_n;

`ifdef ROT_STALL_TIMEOUT_EN
    localparam int TMR_W = $clog2(STALL_CYCLES + 1);

    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_n;
    logic             stall_n;
`endif

    assign count_inc = count + 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            target <= '0;
            count  <= '0;
            flag   <= 1'b0;
            done   <= 1'b0;
`ifdef ROT_STALL_TIMEOUT_EN
            timer  <= '0;
            stall  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            target <= target_n;
            count  <= count_n;
            flag   <= flag_n;
            done   <= done_n;
`ifdef ROT_STALL_TIMEOUT_EN
            timer  <= timer_n;
            stall  <= stall_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        count_n  = count;
        flag_n   = flag;
        done_n   = 1'b0;
`ifdef ROT_STALL_TIMEOUT_EN
        timer_n  = timer;
        stall_n  = stall;
`endif

        if (change) begin
            // A pending target overrides everything, including an edge that
            // lands on the same clock: that edge is dropped, count restarts.
            state_n  = LOAD;
            target_n = cin;
            count_n  = '0;
            flag_n   = 1'b1;
`ifdef ROT_STALL_TIMEOUT_EN
            timer_n  = '0;
            stall_n  = 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (target == '0) begin
                        state_n = DONE;
                        flag_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = COUNT;
                        flag_n  = 1'b1;
`ifdef ROT_STALL_TIMEOUT_EN
                        timer_n = '0;
`endif
                    end
                end

                COUNT: begin
                    if (hall_edge) begin
                        count_n = count_inc;
`ifdef ROT_STALL_TIMEOUT_EN
                        timer_n = '0;
`endif
                        // Leaving on the edge that hits target means the
                        // counter can never run past it or wrap.
                        if (count_inc == target) begin
                            state_n = DONE;
                            flag_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
`ifdef ROT_STALL_TIMEOUT_EN
                    else if (timer == TMR_W'(STALL_CYCLES - 1)) begin
                        state_n = STALL;
                        stall_n = 1'b1;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
`endif
                end

`ifdef ROT_STALL_TIMEOUT_EN
                STALL: begin
                    // Parked with flag high and count frozen; only a new
                    // load or reset gets out of here.
                    state_n = STALL;
                end
`endif

                IDLE, DONE: begin
                    // Edges ignored, count and flag hold.
                end

                default: begin
                    state_n = IDLE;
                    flag_n  = 1'b0;
                end
            endcase
        end
    end

`ifndef ROT_STALL_TIMEOUT_EN
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_hall_rotation_counter.sv
module tb_hall_rotation_counter;

    localparam int CNT_W = 6;
    localparam int FL    = 2;
`ifdef ROT_STALL_TIMEOUT_EN
    localparam int STALL_N = 50;
`endif

    logic             CLK = 1'b0;
    logic             RESET;
    logic             hallIn;
    logic             change;
    logic [CNT_W-1:0] cin;
    logic             flag;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             stall;

    always #5 CLK = ~CLK;

    hall_rotation_counter #(
        .CNT_W    (CNT_W),
        .FILT_LEN (FL),
        .EDGE_MODE(0)
`ifdef ROT_STALL_TIMEOUT_EN
        ,
        .STALL_CYCLES(STALL_N)
`endif
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .hallIn(hallIn),
        .change(change),
        .cin   (cin),
        .flag  (flag),
        .count (count),
        .done  (done),
        .stall (stall)
    );

    // Clock index: value seen after a rising edge is the index of that edge.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected done pulses: the clock it must appear on and
    // the count it must show.
    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model, kept at move level: a move with target T counts the
    // qualified rising edges that reach the counter while running, stops at T.
    int m_target = 0;
    int m_count  = 0;
    int m_flag   = 0;
    bit m_active = 1'b0;
    int last_rise = 0;

    always @(negedge CLK) begin
        if (!RESET && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_count", int'(count), mon_e.cnt);
                check("done_flag", int'(flag), 0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (!change) cin = CNT_W'($urandom);
    endtask

    task automatic model_reset();
        m_target = 0;
        m_count  = 0;
        m_flag   = 0;
        m_active = 1'b0;
    endtask

    // change held for 'hold' clocks; cin is scrambled except on the last
    // sampled clock, so only the final value may become the target.
    task automatic load(input int t, input int hold);
        exp_t e;
        change = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cin = (i == hold - 1) ? CNT_W'(t) : CNT_W'($urandom);
            tick();
        end
        change   = 1'b0;
        m_target = t;
        m_count  = 0;
        if (t == 0) begin
            m_active = 1'b0;
            m_flag   = 0;
            e.cyc    = cyc + 1;
            e.cnt    = 0;
            sb.push_back(e);
        end else begin
            m_active = 1'b1;
            m_flag   = 1;
        end
    endtask

    // Called right after hallIn is driven high following edge index cyc.
    task automatic note_rise();
        exp_t e;
        last_rise = cyc;
        if (m_active) begin
            m_count++;
            if (m_count == m_target) begin
                e.cyc    = cyc + 3 + FL;
                e.cnt    = m_target;
                sb.push_back(e);
                m_active = 1'b0;
                m_flag   = 0;
            end
        end
    endtask

    // One clean rising edge, with optional single-clock glitches in the low
    // and high phases that the filter must swallow.
    task automatic pulse();
        hallIn = 1'b0;
        repeat ($urandom_range(FL + 1, FL + 4)) tick();
        if ($urandom_range(0, 3) == 0) begin
            hallIn = 1'b1;
            tick();
            hallIn = 1'b0;
            repeat ($urandom_range(FL + 1, FL + 3)) tick();
        end
        hallIn = 1'b1;
        note_rise();
        repeat ($urandom_range(FL + 1, FL + 4)) tick();
        if ($urandom_range(0, 3) == 0) begin
            hallIn = 1'b0;
            tick();
            hallIn = 1'b1;
            repeat ($urandom_range(FL + 1, FL + 3)) tick();
        end
        hallIn = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        repeat (10) tick();
        check({tag, "_count"}, int'(count), m_count);
        check({tag, "_flag"}, int'(flag), m_flag);
        check({tag, "_pending"}, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET  = 1'b1;
        hallIn = 1'b0;
        change = 1'b0;
        cin    = '0;
        repeat (2) tick();
        RESET = 1'b0;
        model_reset();
        tick();

        // Reset state
        check("rst_flag", int'(flag), 0);
        check("rst_count", int'(count), 0);
        check("rst_done", int'(done), 0);
        check("rst_stall", int'(stall), 0);

        // Target 2, three edges: done on the second, third ignored
        load(2, 4);
        repeat (2) tick();
        check("load_flag", int'(flag), 1);
        repeat (3) pulse();
        settle_check("t2");

        // One-clock glitch ignored, wide pulse counted
        load(3, 2);
        repeat (3) tick();
        hallIn = 1'b1;
        tick();
        hallIn = 1'b0;
        settle_check("glitch");
        hallIn = 1'b1;
        note_rise();
        repeat (10) tick();
        hallIn = 1'b0;
        settle_check("wide");
        repeat (2) pulse();
        settle_check("wide_done");

        // change coincident with a counting edge: change wins
        load(3, 1);
        pulse();
        settle_check("coinc_pre");
        hallIn = 1'b1;
        repeat (2 + FL) tick();
        load(3, 1);
        check("coinc_count", int'(count), 0);
        check("coinc_flag", int'(flag), 1);
        repeat (3) pulse();
        settle_check("coinc_done");

        // Zero target completes without edges
        load(0, 2);
        settle_check("zero");

        // Edges while loading are ignored
        change = 1'b1;
        fork
            load(4, 14);
            begin
                hallIn = 1'b1;
                repeat (4) tick();
                hallIn = 1'b0;
            end
        join
        settle_check("in_load");
        repeat (4) pulse();
        settle_check("in_load_done");

        // Largest target
        load(63, 1);
        repeat (64) pulse();
        settle_check("max");

        // Reset in the middle of a move, then edges in IDLE are ignored
        load(5, 1);
        repeat (2) pulse();
        RESET = 1'b1;
        tick();
        check("midrst_flag", int'(flag), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_done", int'(done), 0);
        RESET = 1'b0;
        model_reset();
        tick();
        pulse();
        settle_check("idle");

        // Randomised moves
        for (int it = 0; it < 25; it++) begin
            int t;
            int n;
            t = $urandom_range(0, 6);
            n = (t == 0) ? $urandom_range(0, 1) : $urandom_range(t - 1, t + 2);
            load(t, $urandom_range(1, 4));
            repeat ($urandom_range(0, 3)) tick();
            for (int j = 0; j < n; j++) pulse();
            settle_check("rand");
        end

`ifdef ROT_STALL_TIMEOUT_EN
        // Stall after STALL_N clocks without an edge; change clears it
        load(5, 1);
        pulse();
        while (cyc < last_rise + 3 + FL + STALL_N - 1) tick();
        check("stall_early", int'(stall), 0);
        tick();
        check("stall_set", int'(stall), 1);
        check("stall_flag", int'(flag), 1);
        check("stall_count", int'(count), 1);
        load(2, 1);
        check("stall_clear", int'(stall), 0);
        repeat (2) pulse();
        settle_check("stall_done");
`endif

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
